neumaier_finish: RTL and testbench

NEUMAIER_FINISH -- requirements
Module: neumaier_finish

---
 rtl/neumaier_pkg.sv | 31 +++
 rtl/fp_small_add.sv | 99 +++++++++
 rtl/neumaier_finish.sv | 189 ++++++++++++++++++
 tb/tb_neumaier_finish.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/neumaier_pkg.sv
// -----------------------------------------------------------------------------
// neumaier_pkg
// Shared definitions for the neumaier_finish block:
//   state_e         - controller states (IDLE, ADD_C, ADD_S, DIFF, CORR, ACC,
//                     FIN, OUT)
//   exp_bias()      - exponent bias for a given exponent width
//   max_finite_mag()- magnitude field (exponent|mantissa) of the largest finite
//                     value; there is no inf/NaN, so this is the all-ones field
// -----------------------------------------------------------------------------
package neumaier_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_C = 3'd1,
    ADD_S = 3'd2,
    DIFF  = 3'd3,
    CORR  = 3'd4,
    ACC   = 3'd5,
    FIN   = 3'd6,
    OUT   = 3'd7
  } state_e;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int max_finite_mag(input int exp_w, input int mant_w);
    return (1 << (exp_w + mant_w)) - 1;
  endfunction

endpackage

// File: rtl/fp_small_add.sv
// -----------------------------------------------------------------------------
// fp_small_add
// Combinational adder for the small sign|exponent|mantissa format.
//   a_i, b_i : operands (BIT_WIDTH_I)
//   sum_o    : a_i + b_i, rounded to nearest/ties-to-even
// Subnormal operands and results flush to +0, overflow saturates to the largest
// finite magnitude with the result sign, an exact zero is always +0.
// -----------------------------------------------------------------------------
module fp_small_add
  import neumaier_pkg::*;
#(
  parameter  int EXP_WIDTH_I  = 5,
  parameter  int MANT_WIDTH_I = 2,
  localparam int BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic [BIT_WIDTH_I-1:0] a_i,
  input  logic [BIT_WIDTH_I-1:0] b_i,
  output logic [BIT_WIDTH_I-1:0] sum_o
);

  localparam int EW   = EXP_WIDTH_I;
  localparam int MW   = MANT_WIDTH_I;
  localparam int BW   = BIT_WIDTH_I;
  // Significand with hidden one plus guard, round and sticky bits.
  localparam int SW   = MW + 4;
  localparam int EMAX = (1 << EW) - 1;
  localparam logic [BW-2:0] MAXMAG = (BW-1)'(max_finite_mag(EW, MW));

  logic          a_zero, b_zero, swap;
  logic          l_sign, s_sign;
  logic [EW-1:0] l_exp, s_exp;
  logic [MW-1:0] l_man, s_man, man;
  int            diff, dsat, lz, e;
  logic          found, up;
  logic [SW-1:0] ext_l, ext_s, aligned, norm;
  logic [2*SW-1:0] wide;
  logic [SW:0]   raw;
  logic [MW+1:0] rnd;

  always_comb begin
    a_zero = (a_i[BW-2:MW] == '0);
    b_zero = (b_i[BW-2:MW] == '0);
    // Order by magnitude so the subtraction below never goes negative.
    swap   = (b_i[BW-2:0] > a_i[BW-2:0]);
    l_sign = swap ? b_i[BW-1]     : a_i[BW-1];
    l_exp  = swap ? b_i[BW-2:MW]  : a_i[BW-2:MW];
    l_man  = swap ? b_i[MW-1:0]   : a_i[MW-1:0];
    s_sign = swap ? a_i[BW-1]     : b_i[BW-1];
    s_exp  = swap ? a_i[BW-2:MW]  : b_i[BW-2:MW];
    s_man  = swap ? a_i[MW-1:0]   : b_i[MW-1:0];

    ext_l = {1'b1, l_man, 3'b000};
    ext_s = {1'b1, s_man, 3'b000};
    diff  = int'(l_exp) - int'(s_exp);
    // Beyond SW+1 places the small operand only contributes sticky.
    dsat  = (diff > SW + 1) ? SW + 1 : diff;
    wide  = {ext_s, {SW{1'b0}}} >> dsat;
    aligned = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

    if (l_sign == s_sign) raw = {1'b0, ext_l} + {1'b0, aligned};
    else                  raw = {1'b0, ext_l} - {1'b0, aligned};

    lz    = 0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = SW - 1 - i;
        found = 1'b1;
      end
    end

    if (raw[SW]) begin
      norm = raw[SW:1] | {{(SW-1){1'b0}}, raw[0]};
      e    = int'(l_exp) + 1;
    end else begin
      norm = raw[SW-1:0] << lz;
      e    = int'(l_exp) - lz;
    end

    // norm[2] is guard; norm[1:0] fold into sticky; norm[3] is the kept LSB.
    up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[SW-1:3]} + {{(MW+1){1'b0}}, up};
    if (rnd[MW+1]) begin
      e   = e + 1;
      man = '0;
    end else begin
      man = rnd[MW-1:0];
    end

    if (a_zero && b_zero)  sum_o = '0;
    else if (a_zero)       sum_o = b_i;
    else if (b_zero)       sum_o = a_i;
    else if (raw == '0)    sum_o = '0;
    else if (e <= 0)       sum_o = '0;
    else if (e > EMAX)     sum_o = {l_sign, MAXMAG};
    else                   sum_o = {l_sign, EW'(e), man};
  end

endmodule

// File: rtl/neumaier_finish.sv
// -----------------------------------------------------------------------------
// neumaier_finish
// Merges two partial Neumaier (sum, compensation) pairs into one final sum
// using a single shared fp_small_add, one add per state.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   sum_a_i/comp_a_i,
//   sum_b_i/comp_b_i           : partial pairs, captured on the accepting edge
//   valid_i / ready_o          : input handshake (ready_o only in IDLE)
//   result_o, valid_o / ready_i: output handshake (valid_o only in OUT)
// Macro NEUMAIER_FINISH_COMP_EN: when defined, the full compensated sequence
// ADD_C..FIN runs; otherwise the compensations are ignored and the result is
// sum_a+sum_b through IDLE->ADD_S->OUT.
// -----------------------------------------------------------------------------
module neumaier_finish
  import neumaier_pkg::*;
#(
  parameter  int EXP_WIDTH_I  = 5,
  parameter  int MANT_WIDTH_I = 2,
  localparam int BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [BIT_WIDTH_I-1:0] sum_a_i,
  input  logic [BIT_WIDTH_I-1:0] comp_a_i,
  input  logic [BIT_WIDTH_I-1:0] sum_b_i,
  input  logic [BIT_WIDTH_I-1:0] comp_b_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [BIT_WIDTH_I-1:0] result_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int BW = BIT_WIDTH_I;

  state_e        state_q, state_d;
  logic [BW-1:0] sa_q, sa_d, sb_q, sb_d, result_q, result_d;
  logic [BW-1:0] add_a, add_b, add_s;

`ifdef NEUMAIER_FINISH_COMP_EN
  logic [BW-1:0] ca_q, ca_d, cb_q, cb_d, t_q, t_d, c_q, c_d, x_q, x_d;
  logic [BW-1:0] big, small;
  logic          a_is_big;

  // Larger magnitude operand; sum_a wins a tie.
  assign a_is_big = (sa_q[BW-2:0] >= sb_q[BW-2:0]);
  assign big      = a_is_big ? sa_q : sb_q;
  assign small    = a_is_big ? sb_q : sa_q;
`else
  logic phase_q, phase_d;
  logic unused_comp;
  assign unused_comp = ^{comp_a_i, comp_b_i};
`endif

  fp_small_add #(
    .EXP_WIDTH_I  (EXP_WIDTH_I),
    .MANT_WIDTH_I (MANT_WIDTH_I)
  ) u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_s)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    add_a    = '0;
    add_b    = '0;
`ifdef NEUMAIER_FINISH_COMP_EN
    ca_d = ca_q;
    cb_d = cb_q;
    t_d  = t_q;
    c_d  = c_q;
    x_d  = x_q;
`else
    phase_d = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          sa_d = sum_a_i;
          sb_d = sum_b_i;
`ifdef NEUMAIER_FINISH_COMP_EN
          ca_d    = comp_a_i;
          cb_d    = comp_b_i;
          state_d = ADD_C;
`else
          state_d = ADD_S;
`endif
        end
      end
`ifdef NEUMAIER_FINISH_COMP_EN
      ADD_C: begin
        add_a   = ca_q;
        add_b   = cb_q;
        c_d     = add_s;
        state_d = ADD_S;
      end
      ADD_S: begin
        add_a   = sa_q;
        add_b   = sb_q;
        t_d     = add_s;
        state_d = DIFF;
      end
      DIFF: begin
        // big - t as an add with t's sign flipped.
        add_a   = big;
        add_b   = {~t_q[BW-1], t_q[BW-2:0]};
        x_d     = add_s;
        state_d = CORR;
      end
      CORR: begin
        add_a   = x_q;
        add_b   = small;
        x_d     = add_s;
        state_d = ACC;
      end
      ACC: begin
        add_a   = c_q;
        add_b   = x_q;
        c_d     = add_s;
        state_d = FIN;
      end
      FIN: begin
        add_a    = t_q;
        add_b    = c_q;
        result_d = add_s;
        state_d  = OUT;
      end
`else
      ADD_S: begin
        // Two cycles here so the result appears two edges after acceptance.
        add_a = sa_q;
        add_b = sb_q;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          result_d = add_s;
          state_d  = OUT;
        end
      end
`endif
      OUT: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
`ifdef NEUMAIER_FINISH_COMP_EN
      ca_q <= '0;
      cb_q <= '0;
      t_q  <= '0;
      c_q  <= '0;
      x_q  <= '0;
`else
      phase_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
`ifdef NEUMAIER_FINISH_COMP_EN
      ca_q <= ca_d;
      cb_q <= cb_d;
      t_q  <= t_d;
      c_q  <= c_d;
      x_q  <= x_d;
`else
      phase_q <= phase_d;
`endif
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == OUT);
  assign result_o = result_q;

endmodule

// File: tb/tb_neumaier_finish.sv
// -----------------------------------------------------------------------------
// tb_neumaier_finish
// Directed-vector bench for neumaier_finish (E5M2). Expected values and
// latencies follow NEUMAIER_FINISH_COMP_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_neumaier_finish;

`ifdef NEUMAIER_FINISH_COMP_EN
  localparam int LAT = 6;
  localparam int MID = 2;  // edges from accept to DIFF
  localparam bit COMP = 1'b1;
`else
  localparam int LAT = 2;
  localparam int MID = 1;
  localparam bit COMP = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic [7:0] sum_a_i = '0, comp_a_i = '0, sum_b_i = '0, comp_b_i = '0;
  logic       valid_i = 1'b0, ready_i = 1'b0;
  logic       ready_o, valid_o;
  logic [7:0] result_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  neumaier_finish #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sum_a_i  (sum_a_i),
    .comp_a_i (comp_a_i),
    .sum_b_i  (sum_b_i),
    .comp_b_i (comp_b_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic await_out(output int n);
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] sa, input logic [7:0] ca,
                        input logic [7:0] sb, input logic [7:0] cb, input logic [7:0] exp);
    int n;
    chk({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
    sum_a_i = sa; comp_a_i = ca; sum_b_i = sb; comp_b_i = cb;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    // Inputs change mid-operation and must not affect the result.
    sum_a_i = 8'h55; comp_a_i = 8'h66; sum_b_i = 8'hAA; comp_b_i = 8'h11;
    await_out(n);
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_res"}, {24'd0, result_o}, {24'd0, exp});
    chk({tag, "_busy"}, {31'd0, ready_o}, 32'd0);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk({tag, "_idle"}, {30'd0, valid_o, ready_o}, 32'd1);
  endtask

  initial begin
    int n;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", {24'd0, result_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    run_op("trivial",  8'h3C, 8'h00, 8'h3C, 8'h00, 8'h40);
    run_op("comp",     8'h44, 8'h38, 8'h38, 8'h00, COMP ? 8'h45 : 8'h44);
    run_op("cancel",   8'h3C, 8'h00, 8'hBC, 8'h00, 8'h00);
    run_op("sat_pos",  8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F);
    run_op("sat_neg",  8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF);
    run_op("tie_even", 8'h45, 8'h00, 8'h38, 8'h00, 8'h46);
    run_op("subnorm",  8'h01, 8'h00, 8'h01, 8'h00, 8'h00);

    // Backpressure: hold OUT while a new request waits.
    sum_a_i = 8'h3C; comp_a_i = 8'h00; sum_b_i = 8'h34; comp_b_i = 8'h00;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    sum_a_i = 8'h40; sum_b_i = 8'h40;
    await_out(n);
    chk("bp_lat", n, LAT);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_result", {24'd0, result_o}, 32'h3D);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("bp_back_idle", {30'd0, valid_o, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("bp_accepted", {31'd0, ready_o}, 32'd0);
    await_out(n);
    chk("bp2_lat", n, LAT);
    chk("bp2_res", {24'd0, result_o}, 32'h44);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;

    // Reset in the middle of an operation.
    sum_a_i = 8'h3C; comp_a_i = 8'h00; sum_b_i = 8'h38; comp_b_i = 8'h00;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (MID) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_result", {24'd0, result_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    #2 rst_ni = 1'b1;
    run_op("post_rst", 8'h40, 8'h00, 8'h3C, 8'h00, 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
